// File: rtl/rbm_frame_driver_if.sv
// Host-side bundle between the frame driver and its environment:
// input word stream, core control/data, and the result handshake.
interface rbm_frame_driver_if #(
  parameter int general_input_dim = 784,
  parameter int output_dim        = 10,
  parameter int w_bitlength       = 12,
  parameter int word_width        = 16
);
  localparam int LABEL_W = (output_dim > 1) ? $clog2(output_dim) : 1;

  logic [word_width-1:0]             in_word;
  logic                              in_valid;
  logic                              in_ready;
  logic                              core_reset;
  logic                              core_data_valid;
  logic [general_input_dim-1:0]      core_input;
  logic [output_dim*w_bitlength-1:0] core_output;
  logic                              core_finish;
  logic [LABEL_W-1:0]                label;
  logic [w_bitlength-1:0]            label_score;
  logic                              label_error;
  logic                              label_valid;
  logic                              label_ready;
  logic [15:0]                       frame_count;

  modport master (
    input  in_word, in_valid, core_output, core_finish, label_ready,
    output in_ready, core_reset, core_data_valid, core_input,
           label, label_score, label_error, label_valid, frame_count
  );

  modport slave (
    output in_word, in_valid, core_output, core_finish, label_ready,
    input  in_ready, core_reset, core_data_valid, core_input,
           label, label_score, label_error, label_valid, frame_count
  );
endinterface

// File: rtl/rbm_frame_driver.sv
// Loads a frame from a word stream, pulses core reset, runs the RBM core until finish
// (or timeout), argmaxes the vote counters one class per cycle and emits the label.
module rbm_frame_driver #(
  parameter int general_input_dim = 784,
  parameter int output_dim        = 10,
  parameter int w_bitlength       = 12,
  parameter int word_width        = 16,
  parameter int core_reset_cycles = 2,
  parameter int timeout_cycles    = 0
) (
  input logic               clock,
  input logic               reset,
  rbm_frame_driver_if.master bus
);
  localparam int BEATS   = (general_input_dim + word_width - 1) / word_width;
  localparam int FRAME_W = BEATS * word_width;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LABEL_W = (output_dim > 1) ? $clog2(output_dim) : 1;
  localparam int VOTE_W  = output_dim * w_bitlength;

  localparam logic [2:0] S_LOAD = 3'd0;
  localparam logic [2:0] S_CRST = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_SCAN = 3'd3;
  localparam logic [2:0] S_EMIT = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [FRAME_W-1:0]     frame_q;
  logic [VOTE_W-1:0]      snap_q;
  logic [LABEL_W-1:0]     label_q;
  logic [w_bitlength-1:0] score_q;
  logic [w_bitlength-1:0] cur_score;
  logic                   err_q;
  logic                   in_ready_q;
  logic                   core_reset_q;
  logic                   data_valid_q;
  logic                   label_valid_q;
  logic [15:0]            frame_count_q;
  logic                   beat_fire;
  logic                   run_timeout;

  assign beat_fire   = (state_q == S_LOAD) && in_ready_q && bus.in_valid;
  assign run_timeout = (timeout_cycles != 0) && (cnt_q == 32'(timeout_cycles - 1));
  // cnt_q doubles as the class index while scanning
  assign cur_score   = snap_q[int'(cnt_q[LABEL_W-1:0]) * w_bitlength +: w_bitlength];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        if (beat_fire) begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            cnt_d   = '0;
            state_d = S_CRST;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_CRST: begin
        if (cnt_q == 32'(core_reset_cycles - 1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (bus.core_finish) begin
          cnt_d   = '0;
          state_d = S_SCAN;
        end else if (run_timeout) begin
          cnt_d   = '0;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SCAN: begin
        if (cnt_q == 32'(output_dim - 1)) begin
          cnt_d   = '0;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_EMIT: begin
        if (bus.label_ready) state_d = S_LOAD;
      end
      default: begin
        state_d = S_LOAD;
        beat_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_LOAD;
      beat_q        <= '0;
      cnt_q         <= '0;
      frame_q       <= '0;
      snap_q        <= '0;
      label_q       <= '0;
      score_q       <= '0;
      err_q         <= 1'b0;
      in_ready_q    <= 1'b0;
      core_reset_q  <= 1'b1;
      data_valid_q  <= 1'b0;
      label_valid_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= (state_d == S_LOAD);
      core_reset_q  <= (state_d == S_CRST);
      data_valid_q  <= (state_d == S_RUN);
      label_valid_q <= (state_d == S_EMIT);

      if (beat_fire) frame_q[int'(beat_q) * word_width +: word_width] <= bus.in_word;

      if (state_q == S_RUN) begin
        if (bus.core_finish) begin
          snap_q  <= bus.core_output;
          label_q <= '0;
          score_q <= bus.core_output[w_bitlength-1:0];
          err_q   <= 1'b0;
        end else if (run_timeout) begin
          label_q <= '1;
          score_q <= '0;
          err_q   <= 1'b1;
        end
      end

      // strictly greater keeps the lowest index on ties
      if (state_q == S_SCAN && cur_score > score_q) begin
        label_q <= cnt_q[LABEL_W-1:0];
        score_q <= cur_score;
      end

      if (state_q == S_EMIT && bus.label_ready) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.core_reset      = core_reset_q;
  assign bus.core_data_valid = data_valid_q;
  assign bus.core_input      = frame_q[general_input_dim-1:0];
  assign bus.label           = label_q;
  assign bus.label_score     = score_q;
  assign bus.label_error     = err_q;
  assign bus.label_valid     = label_valid_q;
  assign bus.frame_count     = frame_count_q;
endmodule

// File: tb/tb_rbm_frame_driver.sv
// Directed bench: one driver without timeout for the frame table and reset cases,
// one with a 50-cycle timeout for the stalled-core case.
module tb_rbm_frame_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rbm_frame_driver_if if0 ();
  rbm_frame_driver_if if1 ();

  rbm_frame_driver #(.timeout_cycles(0))  u0 (.clock(clk), .reset(rst), .bus(if0.master));
  rbm_frame_driver #(.timeout_cycles(50)) u1 (.clock(clk), .reset(rst), .bus(if1.master));

  logic [15:0]  in_word     = '0;
  logic [1:0]   iv          = '0;
  logic [119:0] core_output = '0;
  logic         core_finish = 1'b0;
  logic         label_ready = 1'b0;

  assign if0.in_word = in_word;      assign if1.in_word = in_word;
  assign if0.in_valid = iv[0];       assign if1.in_valid = iv[1];
  assign if0.core_output = core_output; assign if1.core_output = core_output;
  assign if0.core_finish = core_finish; assign if1.core_finish = core_finish;
  assign if0.label_ready = label_ready; assign if1.label_ready = label_ready;

  logic [1:0]   rdy, crst, dv, lv, err;
  logic [783:0] ci  [2];
  logic [3:0]   lab [2];
  logic [11:0]  scr [2];
  logic [15:0]  fc  [2];
  assign rdy  = {if1.in_ready, if0.in_ready};
  assign crst = {if1.core_reset, if0.core_reset};
  assign dv   = {if1.core_data_valid, if0.core_data_valid};
  assign lv   = {if1.label_valid, if0.label_valid};
  assign err  = {if1.label_error, if0.label_error};
  assign ci[0] = if0.core_input;   assign ci[1] = if1.core_input;
  assign lab[0] = if0.label;       assign lab[1] = if1.label;
  assign scr[0] = if0.label_score; assign scr[1] = if1.label_score;
  assign fc[0] = if0.frame_count;  assign fc[1] = if1.frame_count;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_fc [2] = '{0, 0};

  typedef struct {
    logic [15:0]  word;
    bit           gapped;
    int           fin_delay;
    logic [119:0] counts;
    logic [3:0]   exp_label;
    logic [11:0]  exp_score;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [799:0] act, input logic [799:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [119:0] pk(input int c0, c1, c2, c3, c4, c5, c6, c7, c8, c9);
    int a [10];
    logic [119:0] r;
    a = '{c0, c1, c2, c3, c4, c5, c6, c7, c8, c9};
    r = '0;
    for (int i = 0; i < 10; i++) r[i*12 +: 12] = 12'(a[i]);
    return r;
  endfunction

  task automatic load_frame(input int sel, input logic [15:0] w, input bit gapped);
    int  sent = 0;
    int  g    = 0;
    logic r, v;
    in_word = w;
    while (sent < 49 && g < 400) begin
      r = rdy[sel];
      v = gapped ? (g % 2 == 0) : 1'b1;
      iv[sel] = v;
      tick();
      if (v && r) sent++;
      g++;
    end
    iv[sel] = 1'b0;
    check("load_beats", sent, 49);
  endtask

  // fin_delay < 0: the core never finishes; bp > 0: label_ready held low that many cycles
  task automatic run_frame(input int sel, input logic [15:0] w, input bit gapped,
                           input logic [119:0] counts, input int fin_delay, input int bp,
                           input logic [3:0] el, input logic [11:0] es, input logic ee);
    int n = 0;
    int k = 0;
    int unstable = 0;
    core_output = counts;
    label_ready = (bp == 0);
    load_frame(sel, w, gapped);
    while (crst[sel] && n < 20) begin n++; tick(); end
    check("crst_len", n, 2);
    check("dv_after_crst", dv[sel], 1'b1);
    check("core_input", ci[sel], {49{w}});
    if (fin_delay >= 0) begin
      for (int i = 0; i < fin_delay; i++) tick();
      core_finish = 1'b1;
      tick();
      k = 1;
      while (!lv[sel] && k < 60) begin k++; tick(); end
      check("finish_to_label", k, 11);
    end else begin
      while (!lv[sel] && k < 200) begin k++; tick(); end
      check("timeout_to_label", k, 50);
    end
    check("dv_low_in_emit", dv[sel], 1'b0);
    check("label", lab[sel], el);
    check("label_score", scr[sel], es);
    check("label_error", err[sel], ee);
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        iv[sel] = 1'b1;
        in_word = 16'hDEAD;
        tick();
        if (!lv[sel] || lab[sel] !== el || scr[sel] !== es || rdy[sel]) unstable++;
      end
      iv[sel] = 1'b0;
      check("backpressure_hold", unstable, 0);
      label_ready = 1'b1;
    end
    tick();
    exp_fc[sel] = (exp_fc[sel] + 1) % 65536;
    check("lv_drop", lv[sel], 1'b0);
    check("ready_after_hs", rdy[sel], 1'b1);
    check("frame_count", fc[sel], exp_fc[sel]);
    core_finish = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{16'hA5C3, 1'b0, 100, pk(3, 7, 30, 1, 0, 0, 0, 0, 0, 2), 4'd2, 12'd30};
    vecs[1] = '{16'hA5C3, 1'b1, 100, pk(3, 7, 30, 1, 0, 0, 0, 0, 0, 2), 4'd2, 12'd30};
    vecs[2] = '{16'h1234, 1'b0, 7, pk(1, 2, 3, 4, 9, 0, 5, 8, 9, 7), 4'd4, 12'd9};
    vecs[3] = '{16'hFFFF, 1'b0, 3, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 4'd0, 12'd0};
    vecs[4] = '{16'h8001, 1'b1, 0, pk(4094, 100, 100, 100, 100, 100, 100, 100, 100, 4095), 4'd9, 12'd4095};
    vecs[5] = '{16'h0F0F, 1'b0, 5, pk(4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095), 4'd0, 12'd4095};
    vecs[6] = '{16'h5A5A, 1'b0, 4, pk(2047, 2048, 2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047), 4'd1, 12'd2048};

    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", rdy[0], 1'b0);
    check("rst_core_reset", crst[0], 1'b1);
    check("rst_dv", dv[0], 1'b0);
    check("rst_core_input", ci[0], 784'd0);
    check("rst_label_valid", lv[0], 1'b0);
    check("rst_label", {lab[0], scr[0], err[0]}, 17'd0);
    check("rst_frame_count", fc[0], 16'd0);
    rst = 1'b0;
    tick();
    check("release_in_ready", rdy[0], 1'b1);
    check("release_core_reset", crst[0], 1'b0);

    for (int v = 0; v < 7; v++)
      run_frame(0, vecs[v].word, vecs[v].gapped, vecs[v].counts, vecs[v].fin_delay, 0,
                vecs[v].exp_label, vecs[v].exp_score, 1'b0);

    // held result, then a clean frame proves the beats offered during EMIT were dropped
    run_frame(0, 16'h3C3C, 1'b0, pk(1, 2, 3, 4, 9, 0, 5, 8, 9, 7), 3, 10, 4'd4, 12'd9, 1'b0);
    run_frame(0, 16'h0001, 1'b1, pk(3, 7, 30, 1, 0, 0, 0, 0, 0, 2), 2, 0, 4'd2, 12'd30, 1'b0);

    // reset while the core is running
    load_frame(0, 16'h7777, 1'b0);
    n = 0;
    while (!dv[0] && n < 20) begin n++; tick(); end
    check("reach_run", dv[0], 1'b1);
    repeat (5) tick();
    rst = 1'b1;
    repeat (3) tick();
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    check("midrun_core_reset", crst[0], 1'b1);
    check("midrun_dv", dv[0], 1'b0);
    check("midrun_label_valid", lv[0], 1'b0);
    check("midrun_frame_count", fc[0], 16'd0);
    check("midrun_in_ready", rdy[0], 1'b0);
    rst = 1'b0;
    tick();
    check("midrun_release_ready", rdy[0], 1'b1);

    run_frame(1, 16'hC0DE, 1'b0, pk(3, 7, 30, 1, 0, 0, 0, 0, 0, 2), -1, 0, 4'd15, 12'd0, 1'b1);
    run_frame(1, 16'hBEEF, 1'b0, pk(3, 7, 30, 1, 0, 0, 0, 0, 0, 2), 20, 0, 4'd2, 12'd30, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
